// File: rtl/fetch_port_sched_if.sv
// Handshake/control bundle between the shared-port scheduler and the pipeline.
// FETCH_PORT_PERF_EN adds the performance counter outputs.
interface fetch_port_sched_if;
  logic hazard;
  logic branch_taken;
  logic data_req;
  logic port_start;
  logic port_sel;
  logic fetch_valid;
  logic data_done;
  logic pc_freeze;
  logic if_freeze;
  logic if_flush;
  logic back_freeze;
`ifdef FETCH_PORT_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  modport master (
    input  hazard, branch_taken, data_req,
    output port_start, port_sel, fetch_valid, data_done,
    output pc_freeze, if_freeze, if_flush, back_freeze
`ifdef FETCH_PORT_PERF_EN
    , output fetch_count, stall_count
`endif
  );

  modport slave (
    output hazard, branch_taken, data_req,
    input  port_start, port_sel, fetch_valid, data_done,
    input  pc_freeze, if_freeze, if_flush, back_freeze
`ifdef FETCH_PORT_PERF_EN
    , input fetch_count, stall_count
`endif
  );
endinterface

// File: rtl/fetch_port_sched.sv
// Shared memory port scheduler: arbitrates fetch vs. data accesses of fixed LATENCY
// and sequences PC/IF freeze and flush. FETCH_PORT_PERF_EN adds fetch/stall counters.
module fetch_port_sched #(
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_port_sched_if.master  bus
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       squash_q, squash_d;

  logic port_start, port_sel, fetch_valid, data_done;
  logic pc_freeze, if_freeze, if_flush, back_freeze;
  logic fetch_start, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    squash_d    = squash_q;
    port_start  = 1'b0;
    port_sel    = 1'b0;
    fetch_valid = 1'b0;
    data_done   = 1'b0;
    pc_freeze   = 1'b1;
    if_freeze   = 1'b1;
    if_flush    = 1'b0;
    back_freeze = 1'b0;
    fetch_start = 1'b0;
    done        = (cnt_q == LAT);

    case (state_q)
      IDLE: begin
        if (bus.data_req) begin
          port_start = 1'b1;
          port_sel   = 1'b1;
          state_d    = DATA;
          cnt_d      = 4'd1;
        end else if (!bus.hazard) begin
          port_start  = 1'b1;
          fetch_start = 1'b1;
          state_d     = FETCH;
          cnt_d       = 4'd1;
        end
      end
      FETCH: begin
        if (!done) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!bus.hazard) begin
          // A held completion (hazard) keeps cnt at LAT; memory output stays stable.
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (!squash_q) begin
            fetch_valid = 1'b1;
            if_freeze   = 1'b0;
            pc_freeze   = 1'b0;
          end
        end
      end
      DATA: begin
        port_sel = 1'b1;
        if (!done) begin
          cnt_d       = cnt_q + 4'd1;
          back_freeze = 1'b1;
        end else begin
          data_done = 1'b1;
          state_d   = IDLE;
          cnt_d     = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Wrong-path marking: anything fetching now or in flight belongs to the old path.
    if (bus.branch_taken && !back_freeze) begin
      if_flush    = 1'b1;
      pc_freeze   = 1'b0;
      fetch_valid = 1'b0;
      if (state_q == FETCH || fetch_start) begin
        squash_d = 1'b1;
      end else if (port_start) begin
        squash_d = 1'b0;
      end
    end else if (port_start) begin
      squash_d = 1'b0;
    end

    if (rst) begin
      port_start  = 1'b0;
      port_sel    = 1'b0;
      fetch_valid = 1'b0;
      data_done   = 1'b0;
      pc_freeze   = 1'b1;
      if_freeze   = 1'b1;
      if_flush    = 1'b0;
      back_freeze = 1'b0;
    end
  end

  assign bus.port_start  = port_start;
  assign bus.port_sel    = port_sel;
  assign bus.fetch_valid = fetch_valid;
  assign bus.data_done   = data_done;
  assign bus.pc_freeze   = pc_freeze;
  assign bus.if_freeze   = if_freeze;
  assign bus.if_flush    = if_flush;
  assign bus.back_freeze = back_freeze;

`ifdef FETCH_PORT_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (fetch_valid) fetch_count_q <= fetch_count_q + 32'd1;
      if (pc_freeze)   stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`endif

endmodule
